// File: rtl/lbp_host_mem_if.sv
// Bus between the LBP engine / image source (master) and the host memory (slave).
interface lbp_host_mem_if;
    // Image load
    logic        img_valid;
    logic [7:0]  img_data;
    // Gray read port
    logic        gray_ready;
    logic        gray_req;
    logic [13:0] gray_addr;
    logic [7:0]  gray_data;
    // LBP result write port
    logic        lbp_valid;
    logic [13:0] lbp_addr;
    logic [7:0]  lbp_data;
    logic        finish;
    // Result dump
    logic        out_valid;
    logic [13:0] out_addr;
    logic [7:0]  out_data;
    logic        done;
    logic        wr_err;

    modport master (
        output img_valid, img_data, gray_req, gray_addr, lbp_valid, lbp_addr, lbp_data, finish,
        input  gray_ready, gray_data, out_valid, out_addr, out_data, done, wr_err
    );

    modport slave (
        input  img_valid, img_data, gray_req, gray_addr, lbp_valid, lbp_addr, lbp_data, finish,
        output gray_ready, gray_data, out_valid, out_addr, out_data, done, wr_err
    );
endinterface

// File: rtl/lbp_host_mem.sv
// Host memory for a 128x128 LBP engine: loads the gray image, serves zero-latency gray
// reads, collects LBP results (border writes rejected) and dumps the result image.
module lbp_host_mem (
    input  logic          clk,
    input  logic          reset,
    lbp_host_mem_if.slave bus
);

    typedef enum logic [1:0] {StLoad, StServe, StDump, StDone} state_e;

    logic [7:0] gmem [16384];
    logic [7:0] rmem [16384];

    state_e      state_q, state_d;
    logic [13:0] ld_cnt_q, ld_cnt_d;
    logic [13:0] dmp_cnt_q, dmp_cnt_d;
    logic        gray_ready_q, gray_ready_d;
    logic        out_valid_q, out_valid_d;
    logic [7:0]  out_data_q, out_data_d;
    logic        done_q, done_d;
    logic        wr_err_q, wr_err_d;

    logic        gmem_we;
    logic        rmem_we;
    logic [13:0] ld_nxt;
    logic [13:0] dmp_nxt;
    logic [13:0] dump_rd_addr;
    logic [7:0]  dump_rd_data;

    // Row 0/127 or column 0/127 of the 128x128 image.
    function automatic logic is_border(input logic [13:0] a);
        return (a[13:7] == 7'd0) || (&a[13:7]) || (a[6:0] == 7'd0) || (&a[6:0]);
    endfunction

    assign ld_nxt  = ld_cnt_q + 14'd1;
    assign dmp_nxt = dmp_cnt_q + 14'd1;

    // Byte to present on the next dump cycle; entry from SERVE presents address 0.
    assign dump_rd_addr = (state_q == StDump) ? dmp_nxt : 14'd0;
    assign dump_rd_data = is_border(dump_rd_addr) ? 8'h00 : rmem[dump_rd_addr];

    // Next-state and registered-output logic.
    always_comb begin
        state_d      = state_q;
        ld_cnt_d     = ld_cnt_q;
        dmp_cnt_d    = dmp_cnt_q;
        gray_ready_d = gray_ready_q;
        out_valid_d  = 1'b0;
        out_data_d   = 8'h00;
        done_d       = done_q;
        wr_err_d     = wr_err_q;
        gmem_we      = 1'b0;
        rmem_we      = 1'b0;
        unique case (state_q)
            StLoad: begin
                if (bus.img_valid) begin
                    gmem_we  = 1'b1;
                    ld_cnt_d = ld_nxt;
                    // Counter wrap marks the last pixel of the image.
                    if (ld_nxt == 14'd0) begin
                        state_d      = StServe;
                        gray_ready_d = 1'b1;
                    end
                end
            end
            StServe: begin
                if (bus.lbp_valid) begin
                    if (is_border(bus.lbp_addr)) begin
                        wr_err_d = 1'b1;
                    end else begin
                        rmem_we = 1'b1;
                    end
                end
                if (bus.finish) begin
                    state_d      = StDump;
                    gray_ready_d = 1'b0;
                    dmp_cnt_d    = 14'd0;
                    out_valid_d  = 1'b1;
                    out_data_d   = dump_rd_data;
                end
            end
            StDump: begin
                dmp_cnt_d = dmp_nxt;
                if (dmp_nxt == 14'd0) begin
                    state_d = StDone;
                    done_d  = 1'b1;
                end else begin
                    out_valid_d = 1'b1;
                    out_data_d  = dump_rd_data;
                end
            end
            StDone: begin
                done_d = 1'b1;
            end
            default: begin
                state_d = StLoad;
            end
        endcase
    end

    // Control state with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= StLoad;
            ld_cnt_q     <= 14'd0;
            dmp_cnt_q    <= 14'd0;
            gray_ready_q <= 1'b0;
            out_valid_q  <= 1'b0;
            out_data_q   <= 8'h00;
            done_q       <= 1'b0;
            wr_err_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            ld_cnt_q     <= ld_cnt_d;
            dmp_cnt_q    <= dmp_cnt_d;
            gray_ready_q <= gray_ready_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            done_q       <= done_d;
            wr_err_q     <= wr_err_d;
        end
    end

    // Memory arrays keep their contents across reset.
    always_ff @(posedge clk) begin
        if (gmem_we && !reset) begin
            gmem[ld_cnt_q] <= bus.img_data;
        end
        if (rmem_we && !reset) begin
            rmem[bus.lbp_addr] <= bus.lbp_data;
        end
    end

    assign bus.gray_ready = gray_ready_q;
    assign bus.gray_data  = (state_q == StServe && bus.gray_req) ? gmem[bus.gray_addr] : 8'h00;
    assign bus.out_valid  = out_valid_q;
    // The dump counter is the presented address.
    assign bus.out_addr   = dmp_cnt_q;
    assign bus.out_data   = out_data_q;
    assign bus.done       = done_q;
    assign bus.wr_err     = wr_err_q;

endmodule

// File: tb/tb_lbp_host_mem.sv
// Self-checking bench for lbp_host_mem: table-driven gray reads, randomized LBP writes
// checked against an array model, full dump compare, and mid-dump reset.
module tb_lbp_host_mem;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    lbp_host_mem_if bus ();

    lbp_host_mem dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: what each memory should hold, and what is known to be written.
    logic [7:0] gm [16384];
    logic [7:0] rm [16384];
    bit         known [16384];
    bit         exp_wr_err;

    typedef struct {
        bit         req;
        int         addr;
        logic [7:0] exp;
    } gvec_t;
    gvec_t gv [8];

    function automatic bit border(input int a);
        int row = a / 128;
        int col = a % 128;
        return (row == 0) || (row == 127) || (col == 0) || (col == 127);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.img_valid = 1'b0;
        bus.img_data  = 8'h00;
        bus.gray_req  = 1'b0;
        bus.gray_addr = 14'd0;
        bus.lbp_valid = 1'b0;
        bus.lbp_addr  = 14'd0;
        bus.lbp_data  = 8'h00;
        bus.finish    = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " gray_ready"}, bus.gray_ready, 0);
        check({tag, " gray_data"},  bus.gray_data, 0);
        check({tag, " out_valid"},  bus.out_valid, 0);
        check({tag, " out_addr"},   bus.out_addr, 0);
        check({tag, " out_data"},   bus.out_data, 0);
        check({tag, " done"},       bus.done, 0);
        check({tag, " wr_err"},     bus.wr_err, 0);
    endtask

    // Stream 16384 bytes with random idle gaps; gray_ready must only rise after the last.
    task automatic load_image(input bit ramp, input int gap_pct);
        bit early = 1'b0;
        for (int i = 0; i < 16384; i++) begin
            while ($urandom_range(99) < gap_pct) begin
                bus.img_valid = 1'b0;
                tick();
                if (bus.gray_ready) early = 1'b1;
            end
            bus.img_valid = 1'b1;
            bus.img_data  = ramp ? i[7:0] : 8'($urandom);
            gm[i] = bus.img_data;
            if (bus.gray_ready) early = 1'b1;
            tick();
        end
        bus.img_valid = 1'b0;
        check("gray_ready early", early, 0);
        check("gray_ready after last byte", bus.gray_ready, 1);
    endtask

    task automatic lbp_write(input int addr, input logic [7:0] data, input bit fin);
        bus.lbp_valid = 1'b1;
        bus.lbp_addr  = 14'(addr);
        bus.lbp_data  = data;
        bus.finish    = fin;
        if (border(addr)) begin
            exp_wr_err = 1'b1;
        end else begin
            rm[addr]    = data;
            known[addr] = 1'b1;
        end
        tick();
        bus.lbp_valid = 1'b0;
        bus.finish    = 1'b0;
    endtask

    // Follow the dump; stop at abort_at (if >= 0) or when out_valid drops, bounded.
    task automatic run_dump(input int abort_at, input bit inject, output int n_seen);
        int n = 0;
        for (int c = 0; c < 17000; c++) begin
            if (!bus.out_valid) break;
            check("dump out_addr", bus.out_addr, 32'(n));
            if (border(n)) begin
                check("dump border data", bus.out_data, 0);
            end else if (known[n]) begin
                check("dump data", bus.out_data, rm[n]);
            end
            if (n == abort_at) begin
                n_seen = n + 1;
                return;
            end
            // Out-of-state strobes during the dump must have no effect.
            bus.lbp_valid = 1'b0;
            bus.img_valid = 1'b0;
            bus.finish    = 1'b0;
            if (inject && n == 3) begin
                bus.lbp_valid = 1'b1;
                bus.lbp_addr  = 14'd10000;
                bus.lbp_data  = ~rm[10000];
                bus.img_valid = 1'b1;
                bus.img_data  = 8'h5A;
                bus.finish    = 1'b1;
            end else if (inject && n == 4) begin
                bus.lbp_valid = 1'b1;
                bus.lbp_addr  = 14'd128;
                bus.lbp_data  = 8'hFF;
            end
            n++;
            tick();
        end
        bus.lbp_valid = 1'b0;
        bus.img_valid = 1'b0;
        bus.finish    = 1'b0;
        n_seen = n;
    endtask

    initial begin
        int n_seen;
        int a;

        gv[0] = '{1'b1, 129,   8'h81};
        gv[1] = '{1'b0, 129,   8'h00};
        gv[2] = '{1'b1, 0,     8'h00};
        gv[3] = '{1'b1, 1,     8'h01};
        gv[4] = '{1'b1, 16383, 8'hFF};
        gv[5] = '{1'b1, 300,   8'h2C};
        gv[6] = '{1'b0, 16383, 8'h00};
        gv[7] = '{1'b1, 8191,  8'hFF};

        for (int i = 0; i < 16384; i++) known[i] = 1'b0;
        exp_wr_err = 1'b0;

        idle_inputs();
        reset = 1'b1;
        tick();
        tick();
        bus.gray_req  = 1'b1;
        bus.gray_addr = 14'd129;
        #1;
        check_all_zero("reset");
        reset = 1'b0;
        tick();
        check_all_zero("after reset");
        bus.gray_req = 1'b0;

        // ---------------- Flow 1: ramp image, aborted mid-dump ----------------
        load_image(1'b1, 10);

        // img_valid in SERVE must not touch GMEM (would land at addresses 0 and 1).
        bus.img_valid = 1'b1;
        bus.img_data  = 8'h77;
        tick();
        tick();
        bus.img_valid = 1'b0;

        for (int k = 0; k < 8; k++) begin
            bus.gray_req  = gv[k].req;
            bus.gray_addr = 14'(gv[k].addr);
            #1;
            check($sformatf("gray table %0d", k), bus.gray_data, gv[k].exp);
        end
        bus.gray_req = 1'b0;

        lbp_write(130, 8'hA5, 1'b0);
        check("wr_err after interior write", bus.wr_err, 0);
        lbp_write(128, 8'hFF, 1'b0);
        check("wr_err after border write", bus.wr_err, 1);
        for (int k = 0; k < 200; k++) begin
            lbp_write(int'($urandom_range(16383)), 8'($urandom), 1'b0);
        end
        lbp_write(200, 8'h3C, 1'b1);
        check("flow1 out_valid at dump start", bus.out_valid, 1);
        check("flow1 gray_ready drops", bus.gray_ready, 0);
        check("flow1 wr_err", bus.wr_err, 32'(exp_wr_err));

        run_dump(5000, 1'b0, n_seen);
        check("flow1 dump reached 5000", n_seen, 5001);
        reset = 1'b1;
        bus.gray_req  = 1'b1;
        bus.gray_addr = 14'd129;
        #1;
        check_all_zero("mid-dump reset");
        tick();
        reset = 1'b0;
        exp_wr_err = 1'b0;
        bus.gray_req = 1'b0;
        tick();

        // ---------------- Flow 2: random image, full dump ----------------
        // LBP writes and finish during LOAD are ignored.
        bus.lbp_valid = 1'b1;
        bus.lbp_addr  = 14'd0;
        bus.lbp_data  = 8'h55;
        bus.finish    = 1'b1;
        tick();
        bus.lbp_addr  = 14'd130;
        bus.lbp_data  = 8'h00;
        tick();
        bus.lbp_valid = 1'b0;
        bus.finish    = 1'b0;
        check("load-phase lbp wr_err", bus.wr_err, 0);
        check("load-phase gray_ready", bus.gray_ready, 0);

        load_image(1'b0, 12);

        for (int k = 0; k < 60; k++) begin
            a = int'($urandom_range(16383));
            bus.gray_req  = 1'b1;
            bus.gray_addr = 14'(a);
            #1;
            check("random gray read", bus.gray_data, gm[a]);
            tick();
        end
        bus.gray_req = 1'b0;

        lbp_write(10000, 8'h11, 1'b0);
        for (int k = 0; k < 150; k++) begin
            a = int'($urandom_range(16383));
            if (!border(a)) lbp_write(a, 8'($urandom), 1'b0);
        end
        lbp_write(200, 8'h3C, 1'b1);
        bus.gray_req  = 1'b1;
        bus.gray_addr = 14'd129;
        #1;
        check("flow2 out_valid at dump start", bus.out_valid, 1);
        check("gray_data zero in dump", bus.gray_data, 0);
        bus.gray_req = 1'b0;

        run_dump(-1, 1'b1, n_seen);
        check("dump length", n_seen, 16384);
        check("done after dump", bus.done, 1);
        check("out_valid after dump", bus.out_valid, 0);
        tick();
        tick();
        tick();
        check("done sticky", bus.done, 1);
        check("out_valid stays low", bus.out_valid, 0);
        check("flow2 wr_err", bus.wr_err, 32'(exp_wr_err));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/lbp_host_mem.md
LBP_HOST_MEM -- requirements
Module: lbp_host_mem

Interface
REQ-001 SHALL provide: clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL provide: reset  input  1  asynchronous, active-high; clears all state immediately.
REQ-003 SHALL provide: img_valid  input  1  image-load byte strobe.
REQ-004 SHALL provide: img_data  input  8  gray pixel byte; raster order, address 0 first.
REQ-005 SHALL provide: gray_ready  output  1  image loaded; gray reads may begin.
REQ-006 SHALL provide: gray_req  input  1  gray read request from LBP engine.
REQ-007 SHALL provide: gray_addr  input  14  gray pixel address, row*128+col.
REQ-008 SHALL provide: gray_data  output  8  gray pixel at gray_addr.
REQ-009 SHALL provide: lbp_valid  input  1  LBP result write strobe.
REQ-010 SHALL provide: lbp_addr  input  14  LBP result address.
REQ-011 SHALL provide: lbp_data  input  8  LBP result byte.
REQ-012 SHALL provide: finish  input  1  LBP engine done.
REQ-013 SHALL provide: out_valid  output  1  result dump strobe.
REQ-014 SHALL provide: out_addr  output  14  dumped result address.
REQ-015 SHALL provide: out_data  output  8  dumped result byte.
REQ-016 SHALL provide: done  output  1  dump complete; sticky.
REQ-017 SHALL provide: wr_err  output  1  sticky flag; LBP write hit a border address.

Function
REQ-018 SHALL hold two 16384x8 arrays: gray image (GMEM) and LBP result (RMEM); image is 128x128.
REQ-019 SHALL implement FSM states LOAD, SERVE, DUMP, DONE; reset state LOAD.
REQ-020 LOAD: each cycle with img_valid=1 SHALL write img_data to GMEM[ld_cnt] and increment 14-bit ld_cnt; img_valid=0 cycles stall without effect.
REQ-021 LOAD: the write at ld_cnt=16383 SHALL move FSM to SERVE next cycle; gray_ready SHALL be registered and rise in the same cycle as entry to SERVE.
REQ-022 SERVE: gray_data SHALL be combinational GMEM[gray_addr] when gray_req=1; gray_data SHALL be 0 when gray_req=0 or not in SERVE; this provides zero-cycle read latency, so the engine can sample gray_data in the same cycle it presents gray_addr.
REQ-023 SERVE: lbp_valid=1 SHALL write lbp_data to RMEM[lbp_addr] at the clock edge, one write per cycle, with no backpressure.
REQ-024 Border address: row 0, row 127, col 0 or col 127 (lbp_addr[13:7] in {0,127} or lbp_addr[6:0] in {0,127}). A write to a border address SHALL be discarded and SHALL set wr_err.
REQ-025 SERVE: finish=1 sampled SHALL move FSM to DUMP next cycle and drop gray_ready; a lbp_valid in the same cycle as finish SHALL still be written.
REQ-026 DUMP: SHALL emit 16384 consecutive cycles with out_valid=1, out_addr 0..16383 ascending, registered outputs.
REQ-027 DUMP: out_data SHALL be 0 for border addresses and RMEM[out_addr] otherwise; interior addresses never written SHALL read as their last-written value.
REQ-028 After out_addr=16383, FSM SHALL enter DONE: out_valid=0, done=1 held until reset.
REQ-029 Inputs outside their state SHALL be ignored: img_valid outside LOAD; lbp_valid and finish outside SERVE.
REQ-030 Counters SHALL be 14-bit and wrap 16383->0; a counter wrap is the sole end-of-phase condition, with no separate compare width.

Reset
REQ-031 Reset SHALL force: state=LOAD, ld_cnt=0, dump counter=0, gray_ready=0, gray_data=0, out_valid=0, out_addr=0, out_data=0, done=0, wr_err=0.
REQ-032 Reset mid-operation in any state SHALL abort to LOAD; GMEM/RMEM contents are not cleared, and a reload SHALL overwrite GMEM fully.

Verification
REQ-033 Load ramp GMEM[i]=i[7:0] with gaps in img_valid -> gray_ready rises exactly one cycle after the 16384th accepted byte, not before.
REQ-034 SERVE, gray_req=1, gray_addr=129 -> gray_data=0x81 in the same cycle; gray_req=0 -> gray_data=0.
REQ-035 Write lbp_addr=130, data 0xA5, then lbp_addr=128 (col 0), data 0xFF -> wr_err=1; dump shows addr130=0xA5 and addr128=0.
REQ-036 finish with lbp_valid in the same cycle (addr 200, 0x3C) -> dump addr200=0x3C; out_valid high exactly 16384 cycles; done=1 after.
REQ-037 Assert reset during DUMP at out_addr=5000 -> all outputs 0 immediately; FSM returns to LOAD and the full flow repeats correctly.
REQ-038 img_valid pulses during SERVE/DUMP and lbp_valid during LOAD -> no change to GMEM, RMEM or wr_err.
